// File: rtl/x_word_packer.sv
// Packs a byte stream into WORD_W-bit words (first byte in MSBs) and feeds one
// frame of WORDS_PER_LOAD words to the X buffer load port per start pulse.
module x_word_packer #(
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int WORDS_PER_LOAD = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             load_done,
    output logic [DATA_W*BYTES_PER_WORD-1:0] X_load,
    output logic                             valid_input,
    output logic                             load_en,
    output logic                             busy,
    output logic                             done
);

    localparam int WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int BC_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WC_W   = $clog2(WORDS_PER_LOAD + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    logic [BC_W-1:0]     r_byte_cnt;
    logic [WC_W-1:0]     r_word_cnt;
    logic [WORD_W-1:0]   r_pack;
    logic [WORD_W-1:0]   r_x_load;
    logic                r_in_ready;
    logic                r_valid_input;
    logic                r_load_en;
    logic                r_busy;
    logic                r_done;

    logic                w_take;
    logic [WORD_W-1:0]   w_pack_next;

    assign w_take      = r_in_ready & in_valid;
    assign w_pack_next = {r_pack[WORD_W-DATA_W-1:0], in_data};

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, making the block order-independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_byte_cnt    <= '0;
            r_word_cnt    <= '0;
            r_pack        <= '0;
            r_x_load      <= '0;
            r_in_ready    <= 1'b0;
            r_valid_input <= 1'b0;
            r_load_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_valid_input <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FILL;
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_in_ready <= 1'b1;
                        r_load_en  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_take) begin
                        r_pack <= w_pack_next;
                        if (r_byte_cnt == BC_W'(BYTES_PER_WORD - 1)) begin
                            // Last byte: publish straight from the shift path so the word shows next cycle.
                            r_byte_cnt    <= '0;
                            r_x_load      <= w_pack_next;
                            r_valid_input <= 1'b1;
                            r_in_ready    <= 1'b0;
                            r_state       <= S_ISSUE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    r_word_cnt <= r_word_cnt + WC_W'(1);
                    if (r_word_cnt == WC_W'(WORDS_PER_LOAD - 1)) begin
                        r_state   <= S_WAIT;
                        r_load_en <= 1'b0;
                    end else begin
                        r_state    <= S_FILL;
                        r_in_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (load_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_load_en  <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign X_load      = r_x_load;
    assign valid_input = r_valid_input;
    assign load_en     = r_load_en;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
